// File: rtl/matmul_seq_ctrl.sv
// Loop-nest sequencer for the matrix-multiply datapath: walks (i, j, k) over row-major A/B/C buffers.
// Define MATMUL_SEQ_PERF_EN to add the perf_cycles / perf_stalls counters.
module matmul_seq_ctrl #(
   parameter int DIM_W   = 8,
   parameter int ADDR_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DIM_W-1:0]  a_rows,
   input  logic [DIM_W-1:0]  a_cols,
   input  logic [DIM_W-1:0]  b_rows,
   input  logic [DIM_W-1:0]  b_cols,
   output logic              busy,
   output logic              done,
   output logic              err_dim,
   output logic              a_rd_en,
   output logic [ADDR_W-1:0] a_addr,
   output logic              b_rd_en,
   output logic [ADDR_W-1:0] b_addr,
   output logic              mac_clr,
   output logic              mac_en,
   output logic              mac_last,
   output logic              c_wr_en,
   output logic [ADDR_W-1:0] c_addr,
   input  logic              c_wr_ready
`ifdef MATMUL_SEQ_PERF_EN
   ,
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_stalls
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE, S_ERR
   } state_t;

   localparam int WC_W = $clog2(MEM_LAT + 1) + 1;
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_LAT);

   state_t state, state_next;

   logic [DIM_W-1:0]  dim_m, dim_k, dim_n;
   logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt;
   logic [ADDR_W-1:0] a_base, b_ptr, c_ptr;
   logic [WC_W-1:0]   wait_cnt;
   logic [MEM_LAT-1:0] en_pipe, clr_pipe, last_pipe;

   logic start_ok, dim_bad, k_last, j_last, last_elem, issue, write_acc;

   assign start_ok  = start && (state == S_IDLE);
   assign dim_bad   = (a_rows == '0) || (a_cols == '0) || (b_rows == '0) ||
                      (b_cols == '0) || (a_cols != b_rows);
   assign k_last    = (k_cnt == dim_k - DIM_W'(1));
   assign j_last    = (j_cnt == dim_n - DIM_W'(1));
   assign last_elem = (i_cnt == dim_m - DIM_W'(1)) && j_last;
   assign issue     = (state == S_ISSUE);
   assign write_acc = (state == S_WRITE) && c_wr_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = dim_bad ? S_ERR : S_ISSUE;
         S_ISSUE: if (k_last) state_next = S_WAIT;
         S_WAIT:  if (wait_cnt == WAIT_LAST) state_next = S_WRITE;
         S_WRITE: if (c_wr_ready) state_next = last_elem ? S_DONE : S_ISSUE;
         S_DONE:  state_next = S_IDLE;
         S_ERR:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Row-base registers replace multipliers: a_base = i*K, b_ptr = k*N+j, c_ptr = i*N+j.
   always_ff @(posedge clk) begin
      if (reset) begin
         dim_m    <= '0;
         dim_k    <= '0;
         dim_n    <= '0;
         i_cnt    <= '0;
         j_cnt    <= '0;
         k_cnt    <= '0;
         a_base   <= '0;
         b_ptr    <= '0;
         c_ptr    <= '0;
         wait_cnt <= '0;
         err_dim  <= 1'b0;
      end else if (start_ok) begin
         dim_m    <= a_rows;
         dim_k    <= a_cols;
         dim_n    <= b_cols;
         i_cnt    <= '0;
         j_cnt    <= '0;
         k_cnt    <= '0;
         a_base   <= '0;
         b_ptr    <= '0;
         c_ptr    <= '0;
         wait_cnt <= '0;
         err_dim  <= dim_bad;
      end else begin
         case (state)
            S_ISSUE: begin
               k_cnt    <= k_last ? '0 : k_cnt + DIM_W'(1);
               b_ptr    <= b_ptr + ADDR_W'(dim_n);
               wait_cnt <= '0;
            end
            S_WAIT: wait_cnt <= wait_cnt + WC_W'(1);
            S_WRITE: begin
               if (c_wr_ready && !last_elem) begin
                  c_ptr <= c_ptr + ADDR_W'(1);
                  if (j_last) begin
                     j_cnt  <= '0;
                     i_cnt  <= i_cnt + DIM_W'(1);
                     a_base <= a_base + ADDR_W'(dim_k);
                     b_ptr  <= '0;
                  end else begin
                     j_cnt <= j_cnt + DIM_W'(1);
                     b_ptr <= ADDR_W'(j_cnt) + ADDR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // MAC controls trail the read strobes by the buffer latency so they line up with read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         en_pipe   <= '0;
         clr_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         en_pipe[0]   <= issue;
         clr_pipe[0]  <= issue && (k_cnt == '0);
         last_pipe[0] <= issue && k_last;
         for (int s = 1; s < MEM_LAT; s++) begin
            en_pipe[s]   <= en_pipe[s-1];
            clr_pipe[s]  <= clr_pipe[s-1];
            last_pipe[s] <= last_pipe[s-1];
         end
      end
   end

   assign busy     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_WRITE);
   assign done     = (state == S_DONE) || (state == S_ERR);
   assign a_rd_en  = issue;
   assign b_rd_en  = issue;
   assign a_addr   = issue ? a_base + ADDR_W'(k_cnt) : '0;
   assign b_addr   = issue ? b_ptr : '0;
   assign c_wr_en  = (state == S_WRITE);
   assign c_addr   = (state == S_WRITE) ? c_ptr : '0;
   assign mac_en   = en_pipe[MEM_LAT-1];
   assign mac_clr  = clr_pipe[MEM_LAT-1];
   assign mac_last = last_pipe[MEM_LAT-1];

`ifdef MATMUL_SEQ_PERF_EN
   // Saturating counters; they freeze once the sequencer leaves the busy states.
   always_ff @(posedge clk) begin
      if (reset || start_ok) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else begin
         if (busy && (perf_cycles != '1))
            perf_cycles <= perf_cycles + 32'd1;
         if ((state == S_WRITE) && !c_wr_ready && (perf_stalls != '1))
            perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized self-checking bench for matmul_seq_ctrl against a loop-nest reference model.
module tb_matmul_seq_ctrl;

   localparam int DIM_W  = 8;
   localparam int ADDR_W = 16;
   localparam int LAT    = 1;

   logic              clk = 1'b0;
   logic              reset, start, c_wr_ready;
   logic [DIM_W-1:0]  a_rows, a_cols, b_rows, b_cols;
   logic              busy, done, err_dim, a_rd_en, b_rd_en;
   logic              mac_clr, mac_en, mac_last, c_wr_en;
   logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
`ifdef MATMUL_SEQ_PERF_EN
   logic [31:0]       perf_cycles, perf_stalls;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   matmul_seq_ctrl #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .start(start),
      .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
      .busy(busy), .done(done), .err_dim(err_dim),
      .a_rd_en(a_rd_en), .a_addr(a_addr), .b_rd_en(b_rd_en), .b_addr(b_addr),
      .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last),
      .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wr_ready(c_wr_ready)
`ifdef MATMUL_SEQ_PERF_EN
      , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
   );

   task automatic check_output(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int active_bits();
      return $countones({busy, done, err_dim, a_rd_en, b_rd_en, mac_clr, mac_en,
                         mac_last, c_wr_en, a_addr, b_addr, c_addr});
   endfunction

   function automatic int seq_diff(input int got[$], input int exp[$]);
      int d = (got.size() > exp.size()) ? got.size() - exp.size() : exp.size() - got.size();
      for (int x = 0; x < got.size() && x < exp.size(); x++)
         if (got[x] != exp[x]) d++;
      return d;
   endfunction

   // Pulses start for one cycle, then scrambles the dimension inputs to prove they were latched.
   task automatic apply_stimulus(input int m, input int ka, input int kb, input int n);
      @(posedge clk); #1;
      a_rows = 8'(m); a_cols = 8'(ka); b_rows = 8'(kb); b_cols = 8'(n);
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      a_rows = 8'($urandom); a_cols = 8'($urandom);
      b_rows = 8'($urandom); b_cols = 8'($urandom);
   endtask

   // mode 0: ready always high, 1: random ready, 2: first three write cycles stalled.
   task automatic run_mult(input int m, input int k, input int n, input int mode, input bit mid_start);
      int exp_a[$], exp_b[$], exp_c[$], exp_ml[$];
      int got_a[$], got_b[$], got_c[$], got_ml[$];
      bit rd_hist[$];
      int done_t = -1, done_cnt = 0, stalls = 0, align_err = 0, hold_err = 0;
      int busy_cnt = 0, idle_err = 0, prev_c = 0, t = 0, budget;
      bit stalled = 1'b0, ready_now, exp_en;

      for (int i = 0; i < m; i++)
         for (int j = 0; j < n; j++) begin
            exp_c.push_back(i*n + j);
            for (int kk = 0; kk < k; kk++) begin
               exp_a.push_back(i*k + kk);
               exp_b.push_back(kk*n + j);
               exp_ml.push_back(((kk == 0) ? 2 : 0) + ((kk == k-1) ? 1 : 0));
            end
         end
      budget = 1 + m*n*(k + LAT + 2)*4 + 40;

      apply_stimulus(m, k, k, n);
      while (done_cnt == 0 && t < budget) begin
         @(negedge clk); t++;
         case (mode)
            0:       ready_now = 1'b1;
            1:       ready_now = ($urandom_range(0, 2) != 0);
            default: ready_now = (stalls >= 3);
         endcase
         c_wr_ready = ready_now;
         if (mid_start && t == 3) begin
            start = 1'b1;
            a_rows = 8'($urandom_range(1, 5)); a_cols = 8'($urandom_range(1, 5));
            b_rows = a_cols; b_cols = 8'($urandom_range(1, 5));
         end
         if (mid_start && t == 4) start = 1'b0;
         if (t == 1) check_output("err_clear", err_dim, 0);

         if (a_rd_en) begin
            got_a.push_back(int'(a_addr));
            got_b.push_back(int'(b_addr));
         end
         if (b_rd_en != a_rd_en) align_err++;
         exp_en = (rd_hist.size() >= LAT) ? rd_hist[rd_hist.size()-LAT] : 1'b0;
         if (mac_en != exp_en) align_err++;
         rd_hist.push_back(a_rd_en);
         if (mac_en) got_ml.push_back((mac_clr ? 2 : 0) + (mac_last ? 1 : 0));
         else if (mac_clr || mac_last) align_err++;

         if (stalled && (!c_wr_en || int'(c_addr) != prev_c)) hold_err++;
         stalled = 1'b0;
         if (c_wr_en) begin
            if (ready_now) got_c.push_back(int'(c_addr));
            else begin
               stalls++;
               stalled = 1'b1;
               prev_c  = int'(c_addr);
            end
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_t = t;
            check_output("done_err", err_dim, 0);
         end
      end
      for (int e = 0; e < 4; e++) begin
         @(negedge clk);
         if (done || busy || a_rd_en || c_wr_en || mac_en) idle_err++;
      end
      c_wr_ready = 1'b1;

      check_output("done_seen", done_cnt, 1);
      check_output("done_cycle", done_t, 1 + m*n*(k + LAT + 2) + stalls);
      check_output("a_seq_err", seq_diff(got_a, exp_a), 0);
      check_output("b_seq_err", seq_diff(got_b, exp_b), 0);
      check_output("c_seq_err", seq_diff(got_c, exp_c), 0);
      check_output("mac_seq_err", seq_diff(got_ml, exp_ml), 0);
      check_output("align_err", align_err, 0);
      check_output("hold_err", hold_err, 0);
      check_output("busy_cycles", busy_cnt, done_t - 1);
      check_output("idle_after", idle_err, 0);
      if (mode == 2) check_output("stall_count", stalls, 3);
`ifdef MATMUL_SEQ_PERF_EN
      check_output("perf_cycles", perf_cycles, done_t - 1);
      check_output("perf_stalls", perf_stalls, stalls);
`endif
   endtask

   task automatic run_err(input int m, input int ka, input int kb, input int n);
      int act = 0, extra_done = 0;
      apply_stimulus(m, ka, kb, n);
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk);
         if (t == 1) begin
            check_output("err_done", done, 1);
            check_output("err_flag", err_dim, 1);
            check_output("err_busy", busy, 0);
         end else if (done) extra_done++;
         if (a_rd_en || b_rd_en || c_wr_en || mac_en) act++;
         if (t == 4) check_output("err_held", err_dim, 1);
      end
      check_output("err_activity", act, 0);
      check_output("err_extra_done", extra_done, 0);
   endtask

   task automatic run_reset_abort();
      int act = 0;
      apply_stimulus(2, 2, 2, 2);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_output("abort_outs_zero", active_bits(), 0);
      reset = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (done || c_wr_en || a_rd_en || busy) act++;
      end
      check_output("abort_quiet", act, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; c_wr_ready = 1'b1;
      a_rows = '0; a_cols = '0; b_rows = '0; b_cols = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_outs_zero", active_bits(), 0);
`ifdef MATMUL_SEQ_PERF_EN
      check_output("reset_perf", perf_cycles + perf_stalls, 0);
`endif
      reset = 1'b0;

      run_mult(2, 2, 2, 0, 1'b0);
      run_mult(1, 1, 1, 0, 1'b0);
      run_err(2, 3, 2, 2);
      run_mult(2, 2, 2, 0, 1'b0);
      run_mult(2, 2, 2, 2, 1'b0);
      run_reset_abort();
      run_mult(2, 2, 2, 0, 1'b0);
      run_mult(2, 2, 2, 0, 1'b1);
      run_err(0, 3, 3, 2);
      run_mult(3, 1, 2, 0, 1'b0);
      for (int r = 0; r < 8; r++)
         run_mult($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                  1, 1'($urandom_range(0, 1)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer for the matrix-multiply datapath.
- Takes run-time matrix dimensions and walks the (i, j, k) loop nest over row-major A/B/C buffer memories.
- Issues A/B read addresses and drives the clear/enable/last controls of an external MAC accumulator.
- Writes each C element through a ready/valid port; reports busy/done/error to the top-level controller.

Parameters:
- DIM_W, 8, width of each dimension input (max dimension 2^DIM_W-1).
- ADDR_W, 16, buffer address width; must be >= 2*DIM_W.
- MEM_LAT, 1, A/B buffer read latency in cycles (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a multiply; sampled only in IDLE.
- a_rows  in  DIM_W  rows of A (M).
- a_cols  in  DIM_W  columns of A (K).
- b_rows  in  DIM_W  rows of B (must equal K).
- b_cols  in  DIM_W  columns of B (N).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err_dim  out  1  dimension error flag; held until next accepted start.
- a_rd_en  out  1  A buffer read strobe.
- a_addr  out  ADDR_W  A address, i*K+k.
- b_rd_en  out  1  B buffer read strobe.
- b_addr  out  ADDR_W  B address, k*N+j.
- mac_clr  out  1  clear accumulator before this product; aligned with read data.
- mac_en  out  1  accumulate this product; aligned with read data.
- mac_last  out  1  final product of the current element.
- c_wr_en  out  1  C write valid.
- c_addr  out  ADDR_W  C address, i*N+j.
- c_wr_ready  in  1  C write accepted when high together with c_wr_en.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset value: every output is 0; state IDLE; i, j, k counters 0. Reset mid-operation aborts immediately. No further reads or writes, and no done pulse.
- States: IDLE, ISSUE, WAIT, WRITE, DONE, ERR.
- IDLE:
  - start=1 latches M, K, N and clears err_dim.
  - If any dimension is 0 or a_cols!=b_rows, go to ERR. Otherwise go to ISSUE with i=j=k=0.
  - start is ignored in every other state.
- ERR: one cycle. done=1, err_dim=1 (held), busy=0. No memory activity. Returns to IDLE.
- ISSUE:
  - busy=1; a_rd_en=b_rd_en=1 every cycle with addresses for (i,k) and (k,j).
  - k increments each cycle. When k==K-1 this cycle, go to WAIT with k=0.
  - Addresses are generated with incremental adders (row-base registers); no multipliers.
- Control pipeline: mac_en = rd_en delayed MEM_LAT cycles. mac_clr = (rd_en && k==0) delayed MEM_LAT. mac_last = (rd_en && k==K-1) delayed MEM_LAT.
- WAIT: lasts exactly MEM_LAT+1 cycles, so the accumulator holds the final sum. Then go to WRITE.
- WRITE:
  - c_wr_en=1 and c_addr=i*N+j are held stable until c_wr_ready=1.
  - On acceptance of the last element (i==M-1, j==N-1), go to DONE.
  - Otherwise j++ (at j==N-1: j=0, i++), then back to ISSUE.
- DONE: done=1 for one cycle, busy=0, then IDLE. err_dim stays 0.
- Timing with c_wr_ready tied high:
  - Each element takes K + MEM_LAT + 2 cycles.
  - done is asserted exactly 1 + M*N*(K+MEM_LAT+2) cycles after the start cycle.
- Boundaries:
  - K=1: mac_clr and mac_last assert on the same cycle.
  - M=N=K=1 is legal.
  - Maximum dimensions: no address overflow, guaranteed by the ADDR_W constraint.
- busy is high from the cycle after an accepted start through the final WRITE cycle inclusive.

Optional Feature:
- MATMUL_SEQ_PERF_EN defined: adds outputs perf_cycles[31:0] and perf_stalls[31:0], both cleared on an accepted start.
  - perf_cycles counts busy cycles.
  - perf_stalls counts WRITE cycles with c_wr_ready=0.
  - Both saturate at all-ones and hold their values after done.
- Macro undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- M=K=N=2, MEM_LAT=1, ready=1, start at cycle 0:
  - A addresses 0,1,0,1,2,3,2,3; B addresses 0,2,1,3,0,2,1,3.
  - c_addr 0,1,2,3; done at cycle 21.
- a_cols=3, b_rows=2, start: ERR next cycle; done=1 with err_dim=1; no rd_en or c_wr_en ever asserted. The next valid start clears err_dim.
- M=1, K=1, N=1: mac_clr=mac_en=mac_last=1 on the same cycle; a single write to c_addr 0; done at cycle 5.
- M=K=N=2 with c_wr_ready low for 3 cycles on the first write: c_wr_en and c_addr=0 held for 4 cycles; done at cycle 24; perf_stalls=3 (PERF_EN).
- reset asserted during the second ISSUE cycle: next cycle all outputs 0; no write and no done follow. A new start runs normally.
- start pulsed while busy: ignored; dimensions unchanged; the single done occurs at the original expected cycle.
